dma_burst_seq: RTL and testbench
================================

DMA_BURST_SEQ -- requirements
Module: dma_burst_seq

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width of source and destination.
REQ-002 Parameter DATA_BYTES, default 8, bus width in bytes (power of two).
REQ-003 Parameter MAX_BEATS, default 16, maximum beats per burst (power of two, at most 256).
REQ-004 Parameter MAX_OUTST, default 4, maximum write bursts awaiting completion.
REQ-005 clk_i  in  1  clock.
REQ-006 arst_ni  in  1  reset, asynchronous, active-low.
REQ-007 start_i  in  1  single-cycle start pulse.
REQ-008 int_en_i  in  1  interrupt enable.
REQ-009 src_addr_i / dst_addr_i  in  ADDR_W  transfer addresses, sampled on accepted start.
REQ-010 size_i  in  32  transfer size in bytes, sampled on accepted start.
REQ-011 rd_cmd_valid_o / rd_cmd_ready_i  out/in  1  read-burst command handshake.
REQ-012 rd_cmd_addr_o  out  ADDR_W  read-burst address.
REQ-013 rd_cmd_len_o  out  8  read-burst beats minus one.
REQ-014 wr_cmd_valid_o / wr_cmd_ready_i / wr_cmd_addr_o / wr_cmd_len_o  out/in/out/out  1/1/ADDR_W/8  write-burst command, same encoding as read.
REQ-015 wr_done_i  in  1  one write burst completed (B beat).
REQ-016 wr_resp_i  in  2  response for wr_done_i; 2'b00 is OKAY.
REQ-017 busy_o  out  1  transfer in progress.
REQ-018 done_o  out  1  single-cycle completion pulse.
REQ-019 err_o  out  1  sticky error flag.
REQ-020 irq_o  out  1  level interrupt.
REQ-021 remaining_o  out  32  bytes not yet issued as bursts.

Function
REQ-022 The FSM SHALL have states IDLE, CHECK, ISSUE, DRAIN, FINISH.
REQ-023 IDLE->CHECK SHALL occur on start_i; the block SHALL latch addresses and size and clear err_o and irq_o; start_i outside IDLE SHALL be ignored.
REQ-024 CHECK SHALL move to FINISH with err_o=1 when any of src, dst or size is not a multiple of DATA_BYTES, and no command SHALL be issued.
REQ-025 CHECK SHALL move to FINISH with err_o=0 when size is 0, and no command SHALL be issued.
REQ-026 Otherwise CHECK SHALL move to ISSUE.
REQ-027 Burst bytes SHALL be the minimum of remaining, MAX_BEATS*DATA_BYTES, bytes to the next 4 KiB boundary of the current src, and bytes to the next 4 KiB boundary of the current dst.
REQ-028 len SHALL be burst bytes/DATA_BYTES-1.
REQ-029 In ISSUE, with outstanding<MAX_OUTST, rd and wr valid SHALL assert together with identical len.
REQ-030 Each valid SHALL drop on its own handshake, and address/len SHALL hold while valid is high.
REQ-031 A burst is issued when both commands are accepted (same or different cycles).
REQ-032 On issue: src += bytes, dst += bytes, remaining -= bytes, outstanding +1.
REQ-033 After issue, when remaining reaches 0, the FSM SHALL go to DRAIN.
REQ-034 wr_done_i SHALL decrement outstanding; simultaneous issue and done SHALL leave it unchanged.
REQ-035 wr_done_i while outstanding=0 SHALL be ignored.
REQ-036 wr_resp_i!=0 SHALL set err_o, stop new bursts (commands already presented still complete their handshake), and go to DRAIN.
REQ-037 DRAIN->FINISH SHALL occur when outstanding=0.
REQ-038 FINISH SHALL pulse done_o for one cycle, set irq_o if int_en_i, and return to IDLE.
REQ-039 busy_o SHALL be 1 in every state except IDLE.
REQ-040 irq_o SHALL clear on the next accepted start.

Reset
REQ-041 On arst_ni low, state SHALL be IDLE and all outputs, counters, and address registers 0, asynchronously.
REQ-042 Reset mid-transfer SHALL abandon the transfer without issuing further commands or pulsing done_o.

Structure
REQ-043 A shared package dma_pkg SHALL hold the FSM state enum, the 4 KiB page constant, and the response codes.
REQ-044 Burst-size computation SHALL be one sub-module, dma_burst_calc, which is combinational, with inputs src, dst, remaining and output bytes.

Verification
REQ-045 src=0x1000, dst=0x2000, size=256 -> two bursts len=15 each; done_o after both wr_done_i.
REQ-046 src=0x0FF0, dst=0x3000, size=64 -> bursts of 16 B (len=1) then 48 B (len=5).
REQ-047 size=0 -> no commands; done_o within 3 cycles; err_o=0.
REQ-048 src=0x1004 -> no commands; err_o=1; done_o pulses.
REQ-049 wr_cmd_ready_i held 0 for 5 cycles -> no further burst issued; a second wr_done_i with resp=2'b10 -> err_o=1 and no new bursts after drain.
REQ-050 Five-burst transfer with wr_done_i withheld -> exactly 4 bursts issued until one wr_done_i arrives.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA burst sequencer: FSM encoding, page size,
// bus response codes and a small min helper.
package dma_pkg;

  // Legacy-compatible state encodings; the enum below reuses them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CHECK  = ST_CHECK,
    S_ISSUE  = ST_ISSUE,
    S_DRAIN  = ST_DRAIN,
    S_FINISH = ST_FINISH
  } dma_state_e;

  // Bursts must never cross a 4 KiB page.
  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_W     = 12;

  // Write response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: largest burst that fits the remaining bytes,
// the burst-length limit and the current 4 KiB page of both addresses.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [31:0]       remaining_i,
  output logic [31:0]       bytes_o
);

  localparam logic [31:0] MAX_BURST = 32'(MAX_BEATS * DATA_BYTES);

  logic [31:0] src_room;
  logic [31:0] dst_room;
  // Only the page offset matters for the boundary distance.
  logic        unused_addr_hi;

  assign unused_addr_hi = ^{src_i[ADDR_W-1:PAGE_W], dst_i[ADDR_W-1:PAGE_W]};

  // Distance to the next page boundary, then the minimum of all limits.
  always_comb begin
    src_room = 32'(PAGE_BYTES) - 32'(src_i[PAGE_W-1:0]);
    dst_room = 32'(PAGE_BYTES) - 32'(dst_i[PAGE_W-1:0]);
    bytes_o  = min32(min32(remaining_i, MAX_BURST), min32(src_room, dst_room));
  end

endmodule

// File: rtl/dma_burst_seq.sv
// DMA burst sequencer: splits a memory-to-memory transfer into paired
// read/write burst commands, limits bursts in flight, and reports
// completion, errors and an interrupt.
module dma_burst_seq
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned MAX_BEATS  = 16,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              start_i,
  input  logic              int_en_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [31:0]       size_i,
  output logic              rd_cmd_valid_o,
  input  logic              rd_cmd_ready_i,
  output logic [ADDR_W-1:0] rd_cmd_addr_o,
  output logic [7:0]        rd_cmd_len_o,
  output logic              wr_cmd_valid_o,
  input  logic              wr_cmd_ready_i,
  output logic [ADDR_W-1:0] wr_cmd_addr_o,
  output logic [7:0]        wr_cmd_len_o,
  input  logic              wr_done_i,
  input  logic [1:0]        wr_resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              irq_o,
  output logic [31:0]       remaining_o
);

  localparam int unsigned BEAT_SH = $clog2(DATA_BYTES);
  localparam int unsigned OUT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DATA_BYTES - 1);
  localparam logic [31:0]       SIZE_MASK = 32'(DATA_BYTES - 1);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [31:0]       rem_q;
  logic [OUT_W-1:0]  outst_q;
  logic              rd_valid_q, wr_valid_q;
  // A burst is presented and not yet accepted on both channels.
  logic              pend_q;
  logic              err_q, irq_q;

  logic [31:0] burst_bytes;
  logic [7:0]  burst_len;
  logic        rd_fire, wr_fire, issue, done_ok, resp_err, present, misaligned;

  dma_burst_calc #(
    .ADDR_W    (ADDR_W),
    .DATA_BYTES(DATA_BYTES),
    .MAX_BEATS (MAX_BEATS)
  ) u_calc (
    .src_i      (src_q),
    .dst_i      (dst_q),
    .remaining_i(rem_q),
    .bytes_o    (burst_bytes)
  );

  // Calc inputs only change on issue, so len stays stable while pending.
  assign burst_len  = 8'((burst_bytes >> BEAT_SH) - 32'd1);
  assign rd_fire    = rd_valid_q & rd_cmd_ready_i;
  assign wr_fire    = wr_valid_q & wr_cmd_ready_i;
  assign issue      = pend_q & (~rd_valid_q | rd_fire) & (~wr_valid_q | wr_fire);
  assign done_ok    = wr_done_i & (outst_q != '0);
  assign resp_err   = done_ok & (wr_resp_i != RESP_OKAY);
  assign present    = (state_q == S_ISSUE) & ~pend_q & ~resp_err &
                      (outst_q < OUT_W'(MAX_OUTST)) & (rem_q != 32'd0);
  assign misaligned = ((src_q & ADDR_MASK) != '0) | ((dst_q & ADDR_MASK) != '0) |
                      ((rem_q & SIZE_MASK) != 32'd0);

  // Next-state decision for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_CHECK;
      S_CHECK:  begin
        if (misaligned || rem_q == 32'd0) state_d = S_FINISH;
        else                              state_d = S_ISSUE;
      end
      S_ISSUE:  begin
        if (resp_err)                              state_d = S_DRAIN;
        else if (issue && rem_q == burst_bytes)    state_d = S_DRAIN;
      end
      S_DRAIN:  if (outst_q == '0 && !pend_q) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, address/size bookkeeping, command handshakes and status flags.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      outst_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && start_i) begin
        src_q <= src_addr_i;
        dst_q <= dst_addr_i;
        rem_q <= size_i;
        err_q <= 1'b0;
        irq_q <= 1'b0;
      end

      if (state_q == S_CHECK && misaligned) err_q <= 1'b1;
      if (resp_err) err_q <= 1'b1;

      if (rd_fire) rd_valid_q <= 1'b0;
      if (wr_fire) wr_valid_q <= 1'b0;

      if (issue) begin
        src_q  <= src_q + ADDR_W'(burst_bytes);
        dst_q  <= dst_q + ADDR_W'(burst_bytes);
        rem_q  <= rem_q - burst_bytes;
        pend_q <= 1'b0;
      end

      if (present) begin
        rd_valid_q <= 1'b1;
        wr_valid_q <= 1'b1;
        pend_q     <= 1'b1;
      end

      case ({issue, done_ok})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase

      if (state_q == S_FINISH && int_en_i) irq_q <= 1'b1;
    end
  end

  assign rd_cmd_valid_o = rd_valid_q;
  assign wr_cmd_valid_o = wr_valid_q;
  assign rd_cmd_addr_o  = src_q;
  assign wr_cmd_addr_o  = dst_q;
  assign rd_cmd_len_o   = rd_valid_q ? burst_len : 8'd0;
  assign wr_cmd_len_o   = wr_valid_q ? burst_len : 8'd0;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_FINISH);
  assign err_o          = err_q;
  assign irq_o          = irq_q;
  assign remaining_o    = rem_q;

endmodule

// File: tb/tb_dma_burst_seq.sv
// Directed bench for dma_burst_seq: each task drives one scenario and
// checks against hand-computed burst sequences.
module tb_dma_burst_seq;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        int_en_i = 1'b0;
  logic [63:0] src_addr_i = '0, dst_addr_i = '0;
  logic [31:0] size_i = '0;
  logic        rd_cmd_valid_o, rd_cmd_ready_i = 1'b0;
  logic [63:0] rd_cmd_addr_o;
  logic [7:0]  rd_cmd_len_o;
  logic        wr_cmd_valid_o, wr_cmd_ready_i = 1'b0;
  logic [63:0] wr_cmd_addr_o;
  logic [7:0]  wr_cmd_len_o;
  logic        wr_done_i = 1'b0;
  logic [1:0]  wr_resp_i = 2'b00;
  logic        busy_o, done_o, err_o, irq_o;
  logic [31:0] remaining_o;

  int vectors = 0;
  int miscompares = 0;

  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [63:0] rd_addr_log [0:63];
  logic [63:0] wr_addr_log [0:63];
  logic [7:0]  rd_len_log  [0:63];
  logic [7:0]  wr_len_log  [0:63];

  dma_burst_seq dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .start_i(start_i), .int_en_i(int_en_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .size_i(size_i),
    .rd_cmd_valid_o(rd_cmd_valid_o), .rd_cmd_ready_i(rd_cmd_ready_i),
    .rd_cmd_addr_o(rd_cmd_addr_o), .rd_cmd_len_o(rd_cmd_len_o),
    .wr_cmd_valid_o(wr_cmd_valid_o), .wr_cmd_ready_i(wr_cmd_ready_i),
    .wr_cmd_addr_o(wr_cmd_addr_o), .wr_cmd_len_o(wr_cmd_len_o),
    .wr_done_i(wr_done_i), .wr_resp_i(wr_resp_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .irq_o(irq_o),
    .remaining_o(remaining_o)
  );

  always #5 clk_i = ~clk_i;

  // Transaction monitor: log every accepted command and completion pulse.
  always @(posedge clk_i) begin
    if (rd_cmd_valid_o && rd_cmd_ready_i) begin
      rd_addr_log[rd_cnt % 64] = rd_cmd_addr_o;
      rd_len_log[rd_cnt % 64]  = rd_cmd_len_o;
      $display("rd cmd #%0d addr=%h len=%0d", rd_cnt, rd_cmd_addr_o, rd_cmd_len_o);
      rd_cnt++;
    end
    if (wr_cmd_valid_o && wr_cmd_ready_i) begin
      wr_addr_log[wr_cnt % 64] = wr_cmd_addr_o;
      wr_len_log[wr_cnt % 64]  = wr_cmd_len_o;
      $display("wr cmd #%0d addr=%h len=%0d", wr_cnt, wr_cmd_addr_o, wr_cmd_len_o);
      wr_cnt++;
    end
    if (done_o) begin
      $display("done pulse err=%0b", err_o);
      done_cnt++;
    end
  end

  task automatic do_start(input logic [63:0] s, input logic [63:0] d, input logic [31:0] n,
                          input logic ie);
    @(negedge clk_i);
    src_addr_i = s; dst_addr_i = d; size_i = n; int_en_i = ie; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic pulse_done(input logic [1:0] r);
    @(negedge clk_i);
    wr_done_i = 1'b1; wr_resp_i = r;
    @(negedge clk_i);
    wr_done_i = 1'b0; wr_resp_i = 2'b00;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic wait_wr(input int target, input int max);
    int c;
    c = 0;
    while (wr_cnt < target && c < max) begin @(negedge clk_i); c++; end
  endtask

  task automatic wait_done(input int base, input int max, output int cyc);
    cyc = 0;
    while (done_cnt == base && cyc < max) begin @(negedge clk_i); cyc++; end
  endtask

  task automatic test_reset();
    #2;
    vectors++; if ({rd_cmd_valid_o, wr_cmd_valid_o, busy_o, done_o, err_o, irq_o} !== 6'b0) begin miscompares++; $display("FAIL reset_flags got %b want 000000", {rd_cmd_valid_o, wr_cmd_valid_o, busy_o, done_o, err_o, irq_o}); end
    vectors++; if (remaining_o !== 32'd0 || rd_cmd_addr_o !== 64'd0 || wr_cmd_len_o !== 8'd0) begin miscompares++; $display("FAIL reset_values rem=%0d addr=%h len=%0d want 0", remaining_o, rd_cmd_addr_o, wr_cmd_len_o); end
    @(negedge clk_i);
    arst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    int rb, wb, db, cyc;
    rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    rd_cmd_ready_i = 1'b1; wr_cmd_ready_i = 1'b1;
    do_start(64'h1000, 64'h2000, 32'd256, 1'b1);
    wait_wr(wb + 2, 50);
    wait_cycles(3);
    vectors++; if (rd_cnt - rb !== 2 || wr_cnt - wb !== 2) begin miscompares++; $display("FAIL basic_count rd=%0d wr=%0d want 2/2", rd_cnt - rb, wr_cnt - wb); end
    vectors++; if (rd_len_log[rb] !== 8'd15 || rd_len_log[rb+1] !== 8'd15 || wr_len_log[wb] !== 8'd15 || wr_len_log[wb+1] !== 8'd15) begin miscompares++; $display("FAIL basic_len got %0d %0d %0d %0d want 15", rd_len_log[rb], rd_len_log[rb+1], wr_len_log[wb], wr_len_log[wb+1]); end
    vectors++; if (rd_addr_log[rb+1] !== 64'h1080 || wr_addr_log[wb+1] !== 64'h2080) begin miscompares++; $display("FAIL basic_addr got %h %h want 1080 2080", rd_addr_log[rb+1], wr_addr_log[wb+1]); end
    vectors++; if (done_cnt != db || busy_o !== 1'b1) begin miscompares++; $display("FAIL basic_early_done done=%0d busy=%b want 0/1", done_cnt - db, busy_o); end
    pulse_done(2'b00);
    pulse_done(2'b00);
    wait_done(db, 10, cyc);
    @(negedge clk_i);
    vectors++; if (done_cnt - db !== 1 || err_o !== 1'b0 || irq_o !== 1'b1) begin miscompares++; $display("FAIL basic_done done=%0d err=%b irq=%b want 1/0/1", done_cnt - db, err_o, irq_o); end
  endtask

  task automatic test_page_split();
    int rb, wb, db, cyc;
    rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    do_start(64'h0FF0, 64'h3000, 32'd64, 1'b0);
    wait_wr(wb + 2, 50);
    vectors++; if (rd_len_log[rb] !== 8'd1 || rd_len_log[rb+1] !== 8'd5 || wr_len_log[wb] !== 8'd1 || wr_len_log[wb+1] !== 8'd5) begin miscompares++; $display("FAIL split_len got %0d %0d %0d %0d want 1 5 1 5", rd_len_log[rb], rd_len_log[rb+1], wr_len_log[wb], wr_len_log[wb+1]); end
    vectors++; if (rd_addr_log[rb+1] !== 64'h1000 || wr_addr_log[wb+1] !== 64'h3010) begin miscompares++; $display("FAIL split_addr got %h %h want 1000 3010", rd_addr_log[rb+1], wr_addr_log[wb+1]); end
    pulse_done(2'b00);
    pulse_done(2'b00);
    wait_done(db, 10, cyc);
    vectors++; if (done_cnt - db !== 1 || rd_cnt - rb !== 2) begin miscompares++; $display("FAIL split_done done=%0d rd=%0d want 1/2", done_cnt - db, rd_cnt - rb); end
  endtask

  task automatic test_zero_size();
    int rb, db, cyc;
    rb = rd_cnt; db = done_cnt;
    do_start(64'h1000, 64'h2000, 32'd0, 1'b0);
    vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL zero_irq_clear got %b want 0", irq_o); end
    wait_done(db, 10, cyc);
    vectors++; if (done_cnt - db !== 1 || cyc > 3) begin miscompares++; $display("FAIL zero_done done=%0d cycles=%0d want 1 within 3", done_cnt - db, cyc); end
    wait_cycles(2);
    vectors++; if (rd_cnt != rb || err_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL zero_state cmds=%0d err=%b busy=%b want 0/0/0", rd_cnt - rb, err_o, busy_o); end
  endtask

  task automatic test_misaligned();
    int rb, db, cyc;
    rb = rd_cnt; db = done_cnt;
    do_start(64'h1004, 64'h2000, 32'd64, 1'b0);
    wait_done(db, 10, cyc);
    wait_cycles(2);
    vectors++; if (done_cnt - db !== 1 || err_o !== 1'b1) begin miscompares++; $display("FAIL misalign done=%0d err=%b want 1/1", done_cnt - db, err_o); end
    vectors++; if (rd_cnt != rb) begin miscompares++; $display("FAIL misalign_cmds got %0d want 0", rd_cnt - rb); end
  endtask

  task automatic test_wr_stall_err();
    int rb, wb, db, cyc;
    rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    rd_cmd_ready_i = 1'b1; wr_cmd_ready_i = 1'b1;
    do_start(64'h4000, 64'h5000, 32'd512, 1'b0);
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL stall_err_clear got %b want 0", err_o); end
    wait_wr(wb + 1, 50);
    wr_cmd_ready_i = 1'b0;
    wait_cycles(5);
    vectors++; if (rd_cnt - rb !== 2 || wr_cnt - wb !== 1 || rd_cmd_valid_o !== 1'b0 || wr_cmd_valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_hold rd=%0d wr=%0d rv=%b wv=%b want 2/1/0/1", rd_cnt - rb, wr_cnt - wb, rd_cmd_valid_o, wr_cmd_valid_o); end
    rd_cmd_ready_i = 1'b0; wr_cmd_ready_i = 1'b1;
    @(negedge clk_i);
    wr_cmd_ready_i = 1'b0;
    wait_cycles(2);
    vectors++; if (wr_cnt - wb !== 2 || rd_cmd_valid_o !== 1'b1 || wr_cmd_addr_o !== 64'h5100) begin miscompares++; $display("FAIL stall_third wr=%0d rv=%b addr=%h want 2/1/5100", wr_cnt - wb, rd_cmd_valid_o, wr_cmd_addr_o); end
    pulse_done(2'b00);
    pulse_done(2'b10);
    vectors++; if (err_o !== 1'b1 || busy_o !== 1'b1) begin miscompares++; $display("FAIL stall_resp_err err=%b busy=%b want 1/1", err_o, busy_o); end
    rd_cmd_ready_i = 1'b1; wr_cmd_ready_i = 1'b1;
    wait_cycles(8);
    vectors++; if (rd_cnt - rb !== 3 || wr_cnt - wb !== 3 || rd_cmd_valid_o !== 1'b0 || done_cnt != db) begin miscompares++; $display("FAIL stall_drain rd=%0d wr=%0d rv=%b done=%0d want 3/3/0/0", rd_cnt - rb, wr_cnt - wb, rd_cmd_valid_o, done_cnt - db); end
    pulse_done(2'b00);
    wait_done(db, 10, cyc);
    wait_cycles(3);
    vectors++; if (done_cnt - db !== 1 || err_o !== 1'b1 || remaining_o !== 32'd128 || rd_cnt - rb !== 3) begin miscompares++; $display("FAIL stall_finish done=%0d err=%b rem=%0d rd=%0d want 1/1/128/3", done_cnt - db, err_o, remaining_o, rd_cnt - rb); end
  endtask

  task automatic test_outstanding_limit();
    int rb, wb, db, cyc;
    rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    rd_cmd_ready_i = 1'b1; wr_cmd_ready_i = 1'b1;
    do_start(64'h8000, 64'h9000, 32'd640, 1'b0);
    wait_cycles(40);
    vectors++; if (rd_cnt - rb !== 4 || wr_cnt - wb !== 4 || rd_cmd_valid_o !== 1'b0 || remaining_o !== 32'd128) begin miscompares++; $display("FAIL outst_cap rd=%0d wr=%0d rv=%b rem=%0d want 4/4/0/128", rd_cnt - rb, wr_cnt - wb, rd_cmd_valid_o, remaining_o); end
    pulse_done(2'b00);
    wait_cycles(6);
    vectors++; if (rd_cnt - rb !== 5 || wr_addr_log[wb+4] !== 64'h9200) begin miscompares++; $display("FAIL outst_fifth rd=%0d addr=%h want 5/9200", rd_cnt - rb, wr_addr_log[wb+4]); end
    for (int i = 0; i < 4; i++) pulse_done(2'b00);
    wait_done(db, 10, cyc);
    vectors++; if (done_cnt - db !== 1 || err_o !== 1'b0) begin miscompares++; $display("FAIL outst_done done=%0d err=%b want 1/0", done_cnt - db, err_o); end
  endtask

  task automatic test_mid_reset();
    int rb, db;
    rd_cmd_ready_i = 1'b0; wr_cmd_ready_i = 1'b0;
    rb = rd_cnt; db = done_cnt;
    do_start(64'h0, 64'h1000, 32'd256, 1'b1);
    wait_cycles(3);
    vectors++; if (rd_cmd_valid_o !== 1'b1) begin miscompares++; $display("FAIL midrst_pre rv=%b want 1", rd_cmd_valid_o); end
    #2 arst_ni = 1'b0;
    #1;
    vectors++; if ({rd_cmd_valid_o, wr_cmd_valid_o, busy_o, err_o, irq_o} !== 5'b0 || remaining_o !== 32'd0 || wr_cmd_addr_o !== 64'd0) begin miscompares++; $display("FAIL midrst_async flags=%b rem=%0d addr=%h want 0", {rd_cmd_valid_o, wr_cmd_valid_o, busy_o, err_o, irq_o}, remaining_o, wr_cmd_addr_o); end
    @(negedge clk_i);
    arst_ni = 1'b1;
    rd_cmd_ready_i = 1'b1; wr_cmd_ready_i = 1'b1;
    wait_cycles(6);
    vectors++; if (rd_cnt != rb || done_cnt != db || busy_o !== 1'b0) begin miscompares++; $display("FAIL midrst_after cmds=%0d done=%0d busy=%b want 0/0/0", rd_cnt - rb, done_cnt - db, busy_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_page_split();
    test_zero_size();
    test_misaligned();
    test_wr_stall_err();
    test_outstanding_limit();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
